// File: rtl/mii_rx_decoder_if.sv
// Bus bundle for mii_rx_decoder: 64-bit MII receive words in, realigned frame beats out.
// The master side drives the MII words; the slave side is the decoder.
interface mii_rx_decoder_if;
    logic        i_valid;
    logic [63:0] i_mii_rx_d;
    logic [7:0]  i_mii_rx_c;

    logic [63:0] o_data;
    logic        o_data_valid;
    logic [7:0]  o_byte_en;
    logic        o_sof;
    logic        o_eof;
    logic [15:0] o_frame_len;
    logic        o_frame_err;
    logic [31:0] o_frame_count;
    logic [31:0] o_err_count;

    modport master (
        output i_valid, i_mii_rx_d, i_mii_rx_c,
        input  o_data, o_data_valid, o_byte_en, o_sof, o_eof,
               o_frame_len, o_frame_err, o_frame_count, o_err_count
    );

    modport slave (
        input  i_valid, i_mii_rx_d, i_mii_rx_c,
        output o_data, o_data_valid, o_byte_en, o_sof, o_eof,
               o_frame_len, o_frame_err, o_frame_count, o_err_count
    );
endinterface

// File: rtl/mii_rx_decoder.sv
// 64-bit MII receive decoder: strips FB/FD, realigns frame bytes to lane 0, flags runt/oversize/bad control.
// Define MII_RX_STATS_EN to build the good/errored frame counters; otherwise both counter ports read 0.
module mii_rx_decoder #(
    parameter int unsigned MIN_FRAME_BYTES = 71,
    parameter int unsigned MAX_FRAME_BYTES = 1525,
    parameter logic [7:0]  IDLE_CODE       = 8'h07,
    parameter logic [7:0]  START_CODE      = 8'hFB,
    parameter logic [7:0]  EOF_CODE        = 8'hFD
) (
    input  logic            clk,
    input  logic            i_rst,
    mii_rx_decoder_if.slave bus
);
    localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME_BYTES);
    localparam logic [16:0] MAX_LEN  = 17'(MAX_FRAME_BYTES);
    localparam logic [15:0] DROP_LEN = 16'(MAX_FRAME_BYTES + 1);

    typedef enum logic [1:0] {IDLE, DATA, FLUSH, DROP} state_t;

    state_t      r_state,    w_state;
    logic [55:0] r_hold,     w_hold;
    logic [15:0] r_len,      w_len;
    logic        r_first,    w_first;
    logic [7:0]  r_flush_be, w_flush_be;

    logic [63:0] r_data,      w_data;
    logic        r_valid,     w_valid;
    logic [7:0]  r_be,        w_be;
    logic        r_sof,       w_sof;
    logic        r_eof,       w_eof;
    logic        r_err,       w_err;
    logic [15:0] r_frame_len, w_frame_len;

    logic [2:0]  w_k;
    logic [7:0]  w_k_byte;
    logic [16:0] w_total;
    logic [15:0] w_total_sat;
    logic [16:0] w_len_plus8;
    logic        w_runt;
    logic        w_flush_runt;
    logic        w_unused_idle_code;

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // IDLE ends a frame in error like any other non-FD control; it needs no decode of its own.
    assign w_unused_idle_code = ^IDLE_CODE;

    // Lowest control lane decides how the word terminates the frame.
    always_comb begin
        w_k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.i_mii_rx_c[i]) w_k = 3'(i);
        end
    end

    assign w_k_byte     = 8'(bus.i_mii_rx_d >> {w_k, 3'b000});
    assign w_total      = {1'b0, r_len} + {14'd0, w_k};
    assign w_total_sat  = w_total[16] ? 16'hFFFF : w_total[15:0];
    assign w_len_plus8  = {1'b0, r_len} + 17'd8;
    assign w_runt       = w_total < MIN_LEN;
    assign w_flush_runt = {1'b0, r_len} < MIN_LEN;

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
        w_state     = r_state;
        w_hold      = r_hold;
        w_len       = r_len;
        w_first     = r_first;
        w_flush_be  = r_flush_be;
        w_valid     = 1'b0;
        w_data      = '0;
        w_be        = '0;
        w_sof       = 1'b0;
        w_eof       = 1'b0;
        w_err       = 1'b0;
        w_frame_len = '0;

        if (bus.i_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.i_mii_rx_c[0] && bus.i_mii_rx_d[7:0] == START_CODE) begin
                        if (bus.i_mii_rx_c[7:1] == 7'd0) begin
                            w_hold  = bus.i_mii_rx_d[63:8];
                            w_len   = 16'd7;
                            w_first = 1'b1;
                            w_state = DATA;
                        end else begin
                            w_valid = 1'b1;
                            w_sof   = 1'b1;
                            w_eof   = 1'b1;
                            w_err   = 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (bus.i_mii_rx_c == 8'd0) begin
                        if (w_len_plus8 > MAX_LEN) begin
                            w_state = DROP;
                        end else begin
                            w_valid = 1'b1;
                            w_data  = {bus.i_mii_rx_d[7:0], r_hold};
                            w_be    = 8'hFF;
                            w_sof   = r_first;
                            w_first = 1'b0;
                            w_len   = w_len_plus8[15:0];
                            w_hold  = bus.i_mii_rx_d[63:8];
                        end
                    end else if (w_k_byte != EOF_CODE) begin
                        w_valid     = 1'b1;
                        w_data      = {8'h00, r_hold};
                        w_be        = 8'h7F;
                        w_sof       = r_first;
                        w_first     = 1'b0;
                        w_eof       = 1'b1;
                        w_err       = 1'b1;
                        w_frame_len = r_len;
                        w_state     = IDLE;
                    end else if (w_total > MAX_LEN) begin
                        // Tail pushes the frame past the limit: close it exactly like a DROP exit.
                        w_valid     = 1'b1;
                        w_sof       = r_first;
                        w_first     = 1'b0;
                        w_eof       = 1'b1;
                        w_err       = 1'b1;
                        w_frame_len = DROP_LEN;
                        w_state     = IDLE;
                    end else begin
                        w_valid = 1'b1;
                        w_sof   = r_first;
                        w_first = 1'b0;
                        case (w_k)
                            3'd0: begin
                                w_data      = {8'h00, r_hold};
                                w_be        = 8'h7F;
                                w_eof       = 1'b1;
                                w_err       = w_runt;
                                w_frame_len = w_total_sat;
                                w_state     = IDLE;
                            end
                            3'd1: begin
                                w_data      = {bus.i_mii_rx_d[7:0], r_hold};
                                w_be        = 8'hFF;
                                w_eof       = 1'b1;
                                w_err       = w_runt;
                                w_frame_len = w_total_sat;
                                w_state     = IDLE;
                            end
                            default: begin
                                w_data     = {bus.i_mii_rx_d[7:0], r_hold};
                                w_be       = 8'hFF;
                                w_hold     = bus.i_mii_rx_d[63:8];
                                w_len      = w_total_sat;
                                w_flush_be = (8'd1 << (w_k - 3'd1)) - 8'd1;
                                w_state    = FLUSH;
                            end
                        endcase
                    end
                end

                FLUSH: begin
                    w_valid     = 1'b1;
                    w_data      = {8'h00, r_hold} & lane_mask(r_flush_be);
                    w_be        = r_flush_be;
                    w_eof       = 1'b1;
                    w_err       = w_flush_runt;
                    w_frame_len = r_len;
                    w_state     = IDLE;
                end

                DROP: begin
                    if (bus.i_mii_rx_c != 8'd0) begin
                        w_valid     = 1'b1;
                        w_sof       = r_first;
                        w_first     = 1'b0;
                        w_eof       = 1'b1;
                        w_err       = 1'b1;
                        w_frame_len = DROP_LEN;
                        w_state     = IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments here so every register samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_len       <= '0;
            r_first     <= 1'b0;
            r_flush_be  <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_be        <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_err       <= 1'b0;
            r_frame_len <= '0;
        end else begin
            r_state     <= w_state;
            r_hold      <= w_hold;
            r_len       <= w_len;
            r_first     <= w_first;
            r_flush_be  <= w_flush_be;
            r_valid     <= w_valid;
            r_data      <= w_data;
            r_be        <= w_be;
            r_sof       <= w_sof;
            r_eof       <= w_eof;
            r_err       <= w_err;
            r_frame_len <= w_frame_len;
        end
    end

    assign bus.o_data       = r_data;
    assign bus.o_data_valid = r_valid;
    assign bus.o_byte_en    = r_be;
    assign bus.o_sof        = r_sof;
    assign bus.o_eof        = r_eof;
    assign bus.o_frame_err  = r_err;
    assign bus.o_frame_len  = r_frame_len;

`ifdef MII_RX_STATS_EN
    logic [31:0] r_frame_count;
    logic [31:0] r_err_count;

    // Counters step on the same edge that registers the eof beat.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else if (w_eof) begin
            if (w_err) r_err_count   <= r_err_count + 32'd1;
            else       r_frame_count <= r_frame_count + 32'd1;
        end
    end

    assign bus.o_frame_count = r_frame_count;
    assign bus.o_err_count   = r_err_count;
`else
    assign bus.o_frame_count = '0;
    assign bus.o_err_count   = '0;
`endif
endmodule

// File: tb/tb_mii_rx_decoder.sv
// Directed self-checking bench for mii_rx_decoder: frames are built lane by lane and the expected
// beat stream is the frame bytes packed contiguously, eight per beat, from lane 0.
module tb_mii_rx_decoder;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  be;
        logic        sof;
        logic        eof;
        logic        err;
        logic [15:0] len;
    } beat_t;

    typedef struct packed {
        logic       ctl;
        logic [7:0] b;
    } lane_t;

    logic clk = 1'b0;
    logic i_rst;
    always #5 clk = ~clk;

    mii_rx_decoder_if bus();
    mii_rx_decoder dut (.clk(clk), .i_rst(i_rst), .bus(bus));

    beat_t got_q[$];
    beat_t exp_q[$];
    lane_t tx_q[$];
    int    checks   = 0;
    int    failures = 0;

    int frame_n   [7] = '{71, 84, 40, 65, 72, 71, 84};
    bit frame_gap [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Capture every output beat one time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (bus.o_data_valid === 1'b1)
            got_q.push_back({bus.o_data, bus.o_byte_en, bus.o_sof, bus.o_eof,
                             bus.o_frame_err, bus.o_frame_len});
    end

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 13 + 5) & 255);
    endfunction

    task automatic push_ctl(input logic [7:0] code);
        tx_q.push_back({1'b1, code});
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back({1'b0, pat(i)});
    endtask

    task automatic pad_word();
        while (tx_q.size() % 8 != 0) push_ctl(8'h07);
    endtask

    task automatic drive_queue(input bit gaps);
        logic [63:0] d;
        logic [7:0]  c;
        lane_t       x;
        while (tx_q.size() > 0) begin
            for (int l = 0; l < 8; l++) begin
                x = tx_q.pop_front();
                d[8*l +: 8] = x.b;
                c[l] = x.ctl;
            end
            @(negedge clk);
            bus.i_valid = 1'b1; bus.i_mii_rx_d = d; bus.i_mii_rx_c = c;
            if (gaps) begin
                @(negedge clk);
                bus.i_valid = 1'b0; bus.i_mii_rx_d = {8{8'hFB}}; bus.i_mii_rx_c = 8'h01;
            end
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input bit gaps);
        pad_word();
        for (int i = 0; i < 16; i++) push_ctl(8'h07);
        drive_queue(gaps);
    endtask

    task automatic model_frame(input int n, input int len, input logic err, input logic close);
        beat_t b;
        int    nb;
        nb = (n + 7) / 8;
        for (int j = 0; j < nb; j++) begin
            b = '0;
            for (int l = 0; l < 8; l++) begin
                if (j * 8 + l < n) begin
                    b.data[8*l +: 8] = pat(j * 8 + l);
                    b.be[l] = 1'b1;
                end
            end
            b.sof = (j == 0);
            if (close && j == nb - 1) begin
                b.eof = 1'b1;
                b.err = err;
                b.len = 16'(len);
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b0; bus.i_mii_rx_d = '0; bus.i_mii_rx_c = '0;
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_data_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_data_valid);
        end
        checks++;
        if ({bus.o_data, bus.o_byte_en} !== 72'd0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {bus.o_data, bus.o_byte_en});
        end
        checks++;
        if ({bus.o_sof, bus.o_eof, bus.o_frame_err, bus.o_frame_len,
             bus.o_frame_count, bus.o_err_count} !== 83'd0) begin
            failures++;
            $display("FAIL reset_status got=%h exp=0", {bus.o_sof, bus.o_eof, bus.o_frame_err,
                     bus.o_frame_len, bus.o_frame_count, bus.o_err_count});
        end
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frames();
        for (int t = 0; t < 7; t++) begin
            got_q.delete(); exp_q.delete();
            push_ctl(8'hFB); push_data(frame_n[t]); push_ctl(8'hFD);
            send(frame_gap[t]);
            model_frame(frame_n[t], frame_n[t], frame_n[t] < 71, 1'b1);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                failures++;
                $display("FAIL frame_n%0d_gap%0d beat_count got=%0d exp=%0d",
                         frame_n[t], frame_gap[t], got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL frame_n%0d_gap%0d beat%0d got=%h exp=%h",
                             frame_n[t], frame_gap[t], i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_idle_inject();
        got_q.delete(); exp_q.delete();
        // IDLE lands in lane 3 of the fifth word: 31 bytes delivered, 3 bytes of that word lost.
        push_ctl(8'hFB); push_data(34); push_ctl(8'h07);
        send(1'b0);
        model_frame(31, 31, 1'b1, 1'b1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL idle_inject beat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL idle_inject beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bad_start();
        got_q.delete();
        push_ctl(8'hFB); push_ctl(8'h07);
        send(1'b0);
        checks++;
        if (got_q.size() !== 1) begin
            failures++; $display("FAIL bad_start beat_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if ({got_q[0].be, got_q[0].eof, got_q[0].err} !== {8'h00, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL bad_start be_eof_err got=%h/%b/%b exp=00/1/1",
                         got_q[0].be, got_q[0].eof, got_q[0].err);
            end
        end
    endtask

    task automatic test_oversize();
        beat_t b;
        got_q.delete(); exp_q.delete();
        push_ctl(8'hFB); push_data(1600); push_ctl(8'hFD); pad_word();
        push_ctl(8'hFB); push_data(71); push_ctl(8'hFD);
        send(1'b0);
        // 7 + 8*189 = 1519 is the last length not exceeding 1525 after a full word.
        model_frame(189 * 8, 0, 1'b0, 1'b0);
        b = '0; b.eof = 1'b1; b.err = 1'b1; b.len = 16'd1526;
        exp_q.push_back(b);
        model_frame(71, 71, 1'b0, 1'b1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL oversize beat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL oversize beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int eofs;
        got_q.delete(); exp_q.delete();
        push_ctl(8'hFB); push_data(23);
        drive_queue(1'b0);
        @(negedge clk);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        eofs = 0;
        foreach (got_q[i]) if (got_q[i].eof) eofs++;
        checks++;
        if (got_q.size() !== 2 || eofs !== 0) begin
            failures++; $display("FAIL reset_mid_frame aborted beats=%0d eofs=%0d exp beats=2 eofs=0",
                                 got_q.size(), eofs);
        end
        i_rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        push_ctl(8'hFB); push_data(71); push_ctl(8'hFD);
        send(1'b0);
        model_frame(71, 71, 1'b0, 1'b1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL reset_mid_frame beat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL reset_mid_frame beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
`ifdef MII_RX_STATS_EN
        if ({bus.o_frame_count, bus.o_err_count} !== {32'd1, 32'd0}) begin
            failures++; $display("FAIL stats got=%0d/%0d exp=1/0", bus.o_frame_count, bus.o_err_count);
        end
`else
        if ({bus.o_frame_count, bus.o_err_count} !== 64'd0) begin
            failures++; $display("FAIL stats got=%0d/%0d exp=0/0", bus.o_frame_count, bus.o_err_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frames();
        test_idle_inject();
        test_bad_start();
        test_oversize();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
